mem_backend: RTL and testbench

- Backing word memory that sits directly downstream of cache_2way.
- Services miss refills (reads) and write-through stores coming from the cache.
- Models main-memory latency: a multi-cycle read path and a posted write buffer that drains to the array in the background.
- Uses a valid/ready request channel and a single-cycle response pulse, so the cache controller can stall on miss.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_wbuf.sv | 52 +++++
 rtl/mem_backend.sv | 130 +++++++++++++
 tb/tb_mem_backend.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default constants for the cache backing memory.
package mem_pkg;

    localparam int unsigned MEM_ADDR_W    = 5;
    localparam int unsigned MEM_DATA_W    = 32;
    localparam int unsigned READ_LAT_DEF  = 4;
    localparam int unsigned WRITE_LAT_DEF = 2;
    localparam int unsigned WB_DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_READ
    } state_t;

    // One posted write waiting to be committed to the array.
    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/mem_wbuf.sv
// Posted-write FIFO; pointers carry one extra bit to tell full from empty.
module mem_wbuf
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    wb_entry_t        buf_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer update; push and pop may both happen in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Entry storage needs no reset: the pointers define what is live.
    always_ff @(posedge clk) begin
        if (do_push) buf_q[wr_ptr[IDX_W-1:0]] <= push_entry;
    end

    assign head  = buf_q[rd_ptr[IDX_W-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                   (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

endmodule

// File: rtl/mem_backend.sv
// Main-memory model behind the cache: posted writes drain in the background,
// reads wait for the buffer to drain and then take READ_LAT cycles.
module mem_backend
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = MEM_ADDR_W,
    parameter int unsigned DATA_W    = MEM_DATA_W,
    parameter int unsigned READ_LAT  = READ_LAT_DEF,
    parameter int unsigned WRITE_LAT = WRITE_LAT_DEF,
    parameter int unsigned WB_DEPTH  = WB_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              wb_empty
);

    localparam int unsigned WORDS  = 2 ** ADDR_W;
    localparam int unsigned WCNT_W = $clog2(WRITE_LAT + 1);
    localparam int unsigned RCNT_W = $clog2(READ_LAT + 2);
    localparam int unsigned CNT_W  = $clog2(WB_DEPTH) + 1;

    state_t            state;
    logic [RCNT_W-1:0] rd_cnt;
    logic [RCNT_W-1:0] rd_nxt_c;
    logic [ADDR_W-1:0] rd_addr;
    logic [WCNT_W-1:0] wr_cnt;
    logic [DATA_W-1:0] mem_q [WORDS];

    wb_entry_t         wb_head;
    wb_entry_t         wb_in;
    logic              wb_full;
    logic              wb_fifo_empty;
    logic [CNT_W-1:0]  wb_count;
    logic              accept;
    logic              wr_push;
    logic              rd_accept;
    logic              commit;

    assign req_ready = !rst && (state == ST_IDLE) && !wb_full;
    assign accept    = req_valid && req_ready;
    assign wr_push   = accept && req_wr;
    assign rd_accept = accept && !req_wr;
    assign wb_in     = '{addr: MEM_ADDR_W'(req_addr), data: MEM_DATA_W'(req_data)};
    assign commit    = !wb_fifo_empty && (wr_cnt == WCNT_W'(WRITE_LAT - 1));
    assign wb_empty  = (wb_count == '0) && (wr_cnt == '0);
    assign rd_nxt_c  = rd_cnt + RCNT_W'(1);

    mem_wbuf #(
        .DEPTH(WB_DEPTH)
    ) u_wbuf (
        .clk        (clk),
        .rst        (rst),
        .push       (wr_push),
        .push_entry (wb_in),
        .pop        (commit),
        .head       (wb_head),
        .full       (wb_full),
        .empty      (wb_fifo_empty),
        .count      (wb_count)
    );

    // Drain counter: ages the head entry until it is due for commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
        end else if (commit) begin
            wr_cnt <= '0;
        end else if (!wb_fifo_empty) begin
            wr_cnt <= wr_cnt + WCNT_W'(1);
        end
    end

    // Word array; reset clears every word, a due head entry is committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < WORDS; i++) mem_q[i] <= '0;
        end else if (commit) begin
            mem_q[wb_head.addr] <= wb_head.data;
        end
    end

    // Read FSM with registered response; reads never bypass pending writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rd_cnt     <= '0;
            rd_addr    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_accept) begin
                        rd_addr <= req_addr;
                        if (!wb_empty) begin
                            state <= ST_DRAIN;
                        end else begin
                            state  <= ST_READ;
                            rd_cnt <= RCNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (wb_empty) begin
                        state  <= ST_READ;
                        rd_cnt <= RCNT_W'(1);
                    end
                end
                ST_READ: begin
                    rd_cnt <= rd_nxt_c;
                    if (rd_nxt_c >= RCNT_W'(READ_LAT)) begin
                        resp_valid <= 1'b1;
                        resp_data  <= mem_q[rd_addr];
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_backend.sv
// Scoreboard bench for mem_backend: read expectations are queued at issue
// time from a word model and popped when the response pulse arrives.
module tb_mem_backend;

    localparam int RL  = 4;
    localparam int WL  = 2;
    localparam int WBD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [4:0]  req_addr;
    logic [31:0] req_data;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        wb_empty;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [31:0] mem_model [32];
    logic [31:0] sb_q [$];

    mem_backend #(
        .ADDR_W    (5),
        .DATA_W    (32),
        .READ_LAT  (RL),
        .WRITE_LAT (WL),
        .WB_DEPTH  (WBD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .wb_empty   (wb_empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void clear_model();
        for (int i = 0; i < 32; i++) mem_model[i] = '0;
        sb_q.delete();
    endfunction

    // Present one request from a negedge; returns at the negedge after acceptance.
    // acc is the cycle index in which valid && ready was high.
    task automatic issue(input logic wr, input logic [4:0] a, input logic [31:0] d,
                         output int acc);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_data  = d;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout addr=%0d: req_ready=%0b required 1", a, req_ready);
            acc = -1;
        end else if (wr) begin
            mem_model[a] = d;
        end else begin
            sb_q.push_back(mem_model[a]);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_wr    = 1'b0;
    endtask

    // Bounded wait for the response pulse (no comparison here).
    task automatic wait_resp(output bit got, output int at, output logic [31:0] d);
        got = 1'b0;
        at  = -1;
        d   = '0;
        for (int n = 0; n < 300; n++) begin
            if (resp_valid) begin
                got = 1'b1;
                at  = cyc;
                d   = resp_data;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b required 0", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b required 0", resp_valid); end
        n_cmp++; if (resp_data !== 32'h0) begin n_bad++; $display("FAIL rst_resp_data: got %h required 0", resp_data); end
        n_cmp++; if (wb_empty !== 1'b1) begin n_bad++; $display("FAIL rst_wb_empty: got %b required 1", wb_empty); end
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_untouched_read();
        int acc, at;
        bit got;
        logic [31:0] d, exp;
        issue(1'b0, 5'd3, 32'h0, acc);
        wait_resp(got, at, d);
        exp = sb_q.pop_front();
        n_cmp++; if (!got || d !== exp) begin n_bad++; $display("FAIL untouched_data: got %h (valid=%0b) required %h", d, got, exp); end
        n_cmp++; if (at - acc !== RL) begin n_bad++; $display("FAIL untouched_latency: got %0d required %0d", at - acc, RL); end
    endtask

    task automatic test_write_read();
        int acc_w, acc, at;
        bit got;
        logic [31:0] d, exp;
        issue(1'b1, 5'd0, 32'h1, acc_w);
        issue(1'b0, 5'd0, 32'h0, acc);
        wait_resp(got, at, d);
        exp = sb_q.pop_front();
        n_cmp++; if (!got || d !== exp) begin n_bad++; $display("FAIL wr_rd_data: got %h (valid=%0b) required %h", d, got, exp); end
        n_cmp++; if (at - acc !== WL + RL) begin n_bad++; $display("FAIL wr_rd_latency: got %0d required %0d", at - acc, WL + RL); end
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_rd_pulse_width: got %b required 0", resp_valid); end
    endtask

    task automatic test_ordering();
        int acc_w, acc, at;
        bit got;
        logic [31:0] d, exp;
        issue(1'b1, 5'd1, 32'h3, acc_w);
        issue(1'b1, 5'd1, 32'h5, acc);
        issue(1'b1, 5'd1, 32'h7, acc);
        issue(1'b0, 5'd1, 32'h0, acc);
        wait_resp(got, at, d);
        exp = sb_q.pop_front();
        n_cmp++; if (!got || d !== exp) begin n_bad++; $display("FAIL order_data: got %h (valid=%0b) required %h", d, got, exp); end
        // Three commits WL apart from the first write, one cycle for the read
        // to see the empty buffer, then the READ_LAT read path.
        n_cmp++; if (at - acc_w !== 3 * WL + 1 + RL) begin n_bad++; $display("FAIL order_latency: got %0d required %0d", at - acc_w, 3 * WL + 1 + RL); end
    endtask

    task automatic test_back_to_back();
        int m_cnt, m_tick, i, stalls, acc, at, n;
        bit got, pop, exp_rdy, push;
        logic [31:0] d, exp;
        m_cnt = 0; m_tick = 0; i = 0; stalls = 0; n = 0;
        while (i < 8 && n < 100) begin
            exp_rdy = (m_cnt < WBD);
            n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL b2b_ready cyc=%0d: got %b required %b", cyc, req_ready, exp_rdy); end
            req_valid = 1'b1;
            req_wr    = 1'b1;
            req_addr  = 5'(8 + i);
            req_data  = 32'hA000_0000 + 32'(i);
            push = (req_ready === 1'b1);
            pop  = (m_cnt > 0) && (m_tick == WL - 1);
            if (m_cnt > 0) m_tick = pop ? 0 : m_tick + 1;
            m_cnt = m_cnt + int'(push) - int'(pop);
            if (push) begin
                mem_model[req_addr] = req_data;
                i++;
            end else begin
                stalls++;
            end
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        req_wr    = 1'b0;
        n_cmp++; if (i != 8 || stalls == 0) begin n_bad++; $display("FAIL b2b_backpressure: accepted=%0d stalls=%0d required 8 accepts with stalls", i, stalls); end
        for (int k = 0; k < 8; k++) begin
            issue(1'b0, 5'(8 + k), 32'h0, acc);
            wait_resp(got, at, d);
            exp = sb_q.pop_front();
            n_cmp++; if (!got || d !== exp) begin n_bad++; $display("FAIL b2b_data addr=%0d: got %h (valid=%0b) required %h", 8 + k, d, got, exp); end
        end
    endtask

    task automatic test_reset_mid_read();
        int acc, at;
        bit got, seen;
        logic [31:0] d, exp;
        issue(1'b1, 5'd5, 32'hAB, acc);
        issue(1'b0, 5'd5, 32'h0, acc);
        wait_resp(got, at, d);
        exp = sb_q.pop_front();
        n_cmp++; if (!got || d !== exp) begin n_bad++; $display("FAIL pre_reset_data: got %h (valid=%0b) required %h", d, got, exp); end
        issue(1'b0, 5'd5, 32'h0, acc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        seen = resp_valid;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_read_ready: got %b required 1", req_ready); end
        for (int k = 0; k < 8; k++) begin
            if (resp_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_read_no_resp: got %b required 0", seen); end
        issue(1'b0, 5'd5, 32'h0, acc);
        wait_resp(got, at, d);
        exp = sb_q.pop_front();
        n_cmp++; if (!got || d !== exp) begin n_bad++; $display("FAIL mid_read_after_data: got %h (valid=%0b) required %h", d, got, exp); end
    endtask

    task automatic test_reset_mid_drain();
        int acc, at;
        bit got;
        logic [31:0] d, exp;
        issue(1'b1, 5'd6, 32'h11, acc);
        issue(1'b1, 5'd7, 32'h22, acc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        n_cmp++; if (wb_empty !== 1'b1) begin n_bad++; $display("FAIL mid_drain_wb_empty: got %b required 1", wb_empty); end
        for (int k = 6; k < 8; k++) begin
            issue(1'b0, 5'(k), 32'h0, acc);
            wait_resp(got, at, d);
            exp = sb_q.pop_front();
            n_cmp++; if (!got || d !== exp) begin n_bad++; $display("FAIL mid_drain_data addr=%0d: got %h (valid=%0b) required %h", k, d, got, exp); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        clear_model();
        @(negedge clk);
        test_reset();
        test_untouched_read();
        test_write_read();
        test_ordering();
        test_back_to_back();
        test_reset_mid_read();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
